// File: rtl/gate_test_sequencer_pkg.sv
// Shared types and constants for the gate-under-test sequencer.
package gate_test_sequencer_pkg;

  // Controller states. 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

  // Expected truth tables of the lab gates; bit k is the output for input value k.
  localparam logic [1:0] TRUTH_NOT  = 2'b01;
  localparam logic [3:0] TRUTH_AND2 = 4'b1000;
  localparam logic [3:0] TRUTH_OR2  = 4'b1110;
  localparam logic [3:0] TRUTH_XOR2 = 4'b0110;

  // Width of the settle counter; it covers settle times up to 255 cycles.
  localparam int unsigned CNT_W = 8;

  // A sample is a mismatch when the observed GUT output differs from the table entry.
  function automatic logic is_mismatch(input logic observed, input logic expected);
    return observed ^ expected;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_counter.sv
// Settle-time counter: synchronous clear, count enable, terminal count at SETTLE-1.
module gate_test_sequencer_settle_counter
  import gate_test_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/gate_test_sequencer.sv
// Steps a combinational gate-under-test through all input vectors, waits a
// settle time per vector, and checks the sampled output against a truth table.
module gate_test_sequencer
  import gate_test_sequencer_pkg::*;
#(
  parameter int unsigned         N_IN   = 1,
  parameter int unsigned         SETTLE = 4,
  parameter logic [2**N_IN-1:0]  TRUTH  = TRUTH_NOT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] gut_in,
  input  logic            gut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam logic [N_IN-1:0] GIN_ONE  = N_IN'(1);
  localparam logic [N_IN-1:0] GIN_LAST = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_e          state_q;
  logic [N_IN-1:0] gut_in_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_count_q;
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_vec_q;

  logic            cnt_clr_s;
  logic            cnt_en_s;
  logic            tc_s;
  logic            mismatch_s;
  logic            last_vec_s;
  logic [N_IN:0]   err_inc_s;

  gate_test_sequencer_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr_s),
    .en_i  (cnt_en_s),
    .tc_o  (tc_s)
  );

  // Counter control: clear on run launch and after each sample, count while settling.
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_q)
      ST_IDLE:   cnt_clr_s = start & ~abort;
      ST_SETTLE: cnt_en_s  = ~abort;
      ST_SAMPLE: cnt_clr_s = 1'b1;
      default:   cnt_clr_s = 1'b1;
    endcase
  end

  // Sample evaluation against the expected truth table.
  always_comb begin
    mismatch_s = is_mismatch(gut_out, TRUTH[gut_in_q]);
    last_vec_s = (gut_in_q == GIN_LAST);
    err_inc_s  = err_count_q + ERR_ONE;
  end

  // Run controller with registered outputs; abort overrides the current cycle's work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            gut_in_q     <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_SETTLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            gut_in_q <= '0;
            state_q  <= ST_IDLE;
          end else if (tc_s) begin
            state_q <= ST_SAMPLE;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            gut_in_q <= '0;
            state_q  <= ST_IDLE;
          end else begin
            if (mismatch_s) begin
              err_count_q <= err_inc_s;
              if (!fail_valid_q) begin
                fail_vec_q   <= gut_in_q;
                fail_valid_q <= 1'b1;
              end
            end
            if (last_vec_s) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= ~mismatch_s & (err_count_q == '0);
              state_q <= ST_IDLE;
            end else begin
              gut_in_q <= gut_in_q + GIN_ONE;
              state_q  <= ST_SETTLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gut_in     = gut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: an inverter unit (defaults) and an N_IN=2,
// SETTLE=1 unit with an AND2 table driving an OR2 GUT, checked each cycle
// against a run-time-based model plus directed literal expectations.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, abort0, start1, abort1;
  bit   gut_fault;

  logic [0:0] gin0;  logic gout0, busy0, done0, pass0, fvld0;
  logic [1:0] err0;  logic [0:0] fvec0;
  logic [1:0] gin1;  logic gout1, busy1, done1, pass1, fvld1;
  logic [2:0] err1;  logic [1:0] fvec1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign gout0 = gut_fault ? 1'b0 : ~gin0[0];
  assign gout1 = |gin1;

  gate_test_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .gut_in(gin0), .gut_out(gout0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fvld0), .fail_vec(fvec0)
  );

  gate_test_sequencer #(.N_IN(2), .SETTLE(1), .TRUTH(4'b1000)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .gut_in(gin1), .gut_out(gout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fvld1), .fail_vec(fvec1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit busy; bit done; bit pass; bit fvalid;
    int err; int fvec; int gin; int j;
  } mstate_t;

  mstate_t m0, m1;

  function automatic int n_in_of(input int u);   return (u == 0) ? 1 : 2; endfunction
  function automatic int settle_of(input int u); return (u == 0) ? 4 : 1; endfunction
  function automatic int truth_of(input int u);  return (u == 0) ? 1 : 8; endfunction

  function automatic int gut_fn(input int u, input int v);
    if (u == 0) return gut_fault ? 0 : ((v == 0) ? 1 : 0);
    return (v != 0) ? 1 : 0;
  endfunction

  // j counts edges since the launching edge; every (SETTLE+1)-th edge samples a vector.
  function automatic mstate_t mnext(input mstate_t s, input int u, input bit st, input bit ab);
    mstate_t n;
    int per, nv, v;
    n = s;
    per = settle_of(u) + 1;
    nv = 1 << n_in_of(u);
    n.done = 1'b0;
    if (!s.busy) begin
      if (st && !ab) begin
        n.busy = 1'b1; n.pass = 1'b0; n.err = 0; n.fvalid = 1'b0;
        n.fvec = 0; n.gin = 0; n.j = 0;
      end
    end else if (ab) begin
      n.busy = 1'b0; n.pass = 1'b0; n.gin = 0;
    end else begin
      n.j = s.j + 1;
      if (n.j % per == 0) begin
        v = n.j / per - 1;
        if (gut_fn(u, v) != ((truth_of(u) >> v) & 1)) begin
          n.err = s.err + 1;
          if (!s.fvalid) begin n.fvalid = 1'b1; n.fvec = v; end
        end
        if (n.j == nv * per) begin
          n.busy = 1'b0; n.done = 1'b1; n.pass = (n.err == 0); n.gin = v;
        end else begin
          n.gin = v + 1;
        end
      end
    end
    return n;
  endfunction

  // Model state advance, reset asynchronously like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mnext(m0, 0, start0, abort0);
      m1 <= mnext(m1, 1, start1, abort1);
    end
  end

  task automatic cmp_unit(input string t, input mstate_t m, input int gin, input bit b,
                          input bit d, input bit p, input int err, input bit fv, input int fvec);
    chk({t, "_gut_in"}, gin, m.gin);
    chk({t, "_busy"}, int'(b), int'(m.busy));
    chk({t, "_done"}, int'(d), int'(m.done));
    chk({t, "_pass"}, int'(p), int'(m.pass));
    chk({t, "_err_count"}, err, m.err);
    chk({t, "_fail_valid"}, int'(fv), int'(m.fvalid));
    if (m.fvalid) chk({t, "_fail_vec"}, fvec, m.fvec);
  endtask

  // Per-cycle comparison of both units against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      cmp_unit("u0", m0, int'(gin0), busy0, done0, pass0, int'(err0), fvld0, int'(fvec0));
      cmp_unit("u1", m1, int'(gin1), busy1, done1, pass1, int'(err1), fvld1, int'(fvec1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check_all_zero(input string t);
    chk({t, "_u0_outs"}, int'({gin0, busy0, done0, pass0, err0, fvld0, fvec0}), 0);
    chk({t, "_u1_outs"}, int'({gin1, busy1, done1, pass1, err1, fvld1, fvec1}), 0);
  endtask

  task automatic run_unit(input int u, output int cycles, output int n_v0, output int n_v1);
    @(negedge clk);
    if (u == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    cycles = 0; n_v0 = 0; n_v1 = 0;
    while (((u == 0) ? done0 : done1) !== 1'b1 && cycles < 60) begin
      if (((u == 0) ? busy0 : busy1) && ((u == 0) ? int'(gin0) : int'(gin1)) == 0) n_v0++;
      if (((u == 0) ? busy0 : busy1) && ((u == 0) ? int'(gin0) : int'(gin1)) == 1) n_v1++;
      @(negedge clk);
      cycles++;
    end
    chk($sformatf("u%0d_done_within_bound", u), int'((u == 0) ? done0 : done1), 1);
  endtask

  initial begin
    int cyc, v0, v1;
    bit saw_done;
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    gut_fault = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    // Correct inverter: two vectors, 5 cycles each, done 10 edges after launch.
    run_unit(0, cyc, v0, v1);
    chk("inv_done_latency", cyc, 10);
    chk("inv_vec0_cycles", v0, 5);
    chk("inv_vec1_cycles", v1, 5);
    chk("inv_pass", int'(pass0), 1);
    chk("inv_err_count", int'(err0), 0);
    chk("inv_fail_valid", int'(fvld0), 0);

    // Stuck-at-0 GUT: only vector 0 mismatches.
    gut_fault = 1'b1;
    run_unit(0, cyc, v0, v1);
    chk("sa0_done_latency", cyc, 10);
    chk("sa0_pass", int'(pass0), 0);
    chk("sa0_err_count", int'(err0), 1);
    chk("sa0_fail_vec", int'(fvec0), 0);
    chk("sa0_fail_valid", int'(fvld0), 1);

    // OR2 GUT against AND2 table: vectors 1 and 2 mismatch.
    run_unit(1, cyc, v0, v1);
    chk("or2_done_latency", cyc, 8);
    chk("or2_vec0_cycles", v0, 2);
    chk("or2_vec1_cycles", v1, 2);
    chk("or2_err_count", int'(err1), 2);
    chk("or2_fail_vec", int'(fvec1), 1);
    chk("or2_fail_valid", int'(fvld1), 1);
    chk("or2_pass", int'(pass1), 0);

    // Abort on vector 1 with settle count 2, faulty GUT.
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_pre_gut_in", int'(gin0), 1);
    abort0 = 1'b1;
    @(negedge clk); abort0 = 1'b0;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_err_frozen", int'(err0), 1);
    chk("abort_pass", int'(pass0), 0);
    chk("abort_gut_in", int'(gin0), 0);
    saw_done = 1'b0;
    repeat (12) begin @(negedge clk); if (done0) saw_done = 1'b1; end
    chk("abort_no_done_pulse", int'(saw_done), 0);
    run_unit(0, cyc, v0, v1);
    chk("after_abort_done_latency", cyc, 10);
    chk("after_abort_err_count", int'(err0), 1);

    // Asynchronous reset in the middle of SETTLE.
    gut_fault = 1'b0;
    @(negedge clk); start0 = 1'b1; start1 = 1'b1;
    @(negedge clk); start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    run_unit(0, cyc, v0, v1);
    chk("post_reset_done_latency", cyc, 10);
    chk("post_reset_pass", int'(pass0), 1);

    // Start held high: back-to-back runs, done every 11 cycles.
    @(negedge clk); start0 = 1'b1;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
    chk("held_first_done", cyc, 11);
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (done0 !== 1'b1 && cyc < 60);
      chk($sformatf("held_done_period_%0d", k), cyc, 11);
    end
    // start together with abort in IDLE launches nothing.
    abort0 = 1'b1;
    repeat (3) begin @(negedge clk); chk("start_abort_idle_busy", int'(busy0), 0); end
    start0 = 1'b0; abort0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Controller that exercises one combinational gate-under-test (GUT), e.g. the lab inverter.
- Steps the GUT inputs through every input combination and waits a programmable settle time per vector.
- Samples the GUT output and checks it against an expected truth table.
- Reports pass/fail, a mismatch count and the first failing vector. Sits between board switches/buttons (start/abort) and the GUT, with LEDs on the result outputs.

Parameters:
- N_IN, 1, number of GUT inputs; legal range 1..4.
- SETTLE, 4, clock cycles each vector is held before sampling; legal range 1..255.
- TRUTH, 2'b01, expected GUT output per vector, width 2**N_IN; bit k is the expected output for input value k. The default is the inverter: in=0 gives 1, in=1 gives 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level-sampled; launches a run when sampled high in IDLE.
- abort  input  1  terminates a run in progress.
- gut_in  output  N_IN  registered drive to the GUT inputs.
- gut_out  input  1  GUT output; sampled only in SAMPLE.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at normal run completion.
- pass  output  1  1 when the last completed run had zero mismatches.
- err_count  output  N_IN+1  mismatch count of the current or last run.
- fail_valid  output  1  at least one mismatch is recorded.
- fail_vec  output  N_IN  first vector that mismatched.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Asserting it at any time, including mid-run, forces the following immediately:
  - state=IDLE
  - gut_in=0, busy=0, done=0, pass=0
  - err_count=0, fail_valid=0, fail_vec=0
  - settle counter=0
- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - With start=1 and abort=0: gut_in<=0, cnt<=0, err_count<=0, fail_valid<=0, fail_vec<=0, pass<=0, busy<=1, go to SETTLE.
  - Otherwise hold; pass, err_count and fail_* keep the last run's results.
- SETTLE:
  - cnt increments every cycle.
  - When cnt==SETTLE-1, go to SAMPLE. The vector is therefore held exactly SETTLE cycles before SAMPLE.
- SAMPLE, lasting one cycle:
  - Mismatch is gut_out != TRUTH[gut_in].
  - On mismatch: err_count<=err_count+1. If fail_valid=0, also fail_vec<=gut_in and fail_valid<=1.
  - If gut_in != 2**N_IN-1: gut_in<=gut_in+1, cnt<=0, go to SETTLE.
  - On the last vector: busy<=0 and done<=1 for exactly one cycle. pass<=1 if the final error count, including this sample, is zero. Go to IDLE. gut_in holds the last vector.
- Latency: done is high in the cycle after edge E0+2**N_IN*(SETTLE+1), where E0 is the edge that samples start. busy falls on that same edge. With the defaults this is 10 edges.
- Width: err_count cannot overflow, since the maximum is 2**N_IN.
- start while busy is ignored; no queuing.
- abort in SETTLE or SAMPLE: takes priority over that cycle's sample. On the next edge:
  - go to IDLE, busy<=0, pass<=0, gut_in<=0
  - done is not pulsed
  - err_count and fail_* freeze at their partial values
- abort in IDLE has no effect. start and abort both high in IDLE means no run starts.
- start held high continuously: a new run begins on the first IDLE cycle after done, which is the cycle done is high. Back-to-back runs are therefore legal.
- gut_out is not synchronised. The GUT is on the same clock domain and driven only by gut_in, and SETTLE≥1 guarantees a stable sample.

Decomposition:
- Shared package/header holds:
  - state encoding constants: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - default TRUTH constants per lab gate: NOT=2'b01, AND2=4'b1000, OR2=4'b1110, XOR2=4'b0110.
- Optional single sub-module settle_counter (load/enable/terminal-count). All else stays in one module.

Test Plan:
- Defaults with a correct inverter as GUT; start pulse. Expect:
  - gut_in = 0 then 1, each held 5 cycles
  - done after 10 edges
  - pass=1, err_count=0, fail_valid=0
- Defaults with GUT stuck-at-0. Expect pass=0, err_count=1, fail_vec=0, fail_valid=1.
- N_IN=2, TRUTH=4'b1000, SETTLE=1, GUT is OR2. Expect:
  - vectors 0..3, 2 cycles each
  - done after 8 edges
  - err_count=2, fail_vec=1
- abort asserted while gut_in=1, SETTLE cnt=2 (defaults, faulty GUT). Expect:
  - busy low next edge, no done pulse
  - err_count=1 frozen, pass=0
  - then start again gives a full run
- rst_n low mid-SETTLE. Expect all outputs zero immediately, without a clock edge. Release, then start gives a normal run.
- start held high with a correct inverter. Expect:
  - done pulses every 11 cycles (10 run cycles plus the IDLE start cycle)
  - busy high except during the done cycle
  - start/abort together in IDLE launch nothing
